// File: rtl/avalon_memwr_bridge_pkg.sv
// avalon_memwr_bridge_pkg: shared FSM states, Avalon bus widths and lane helper
package avalon_memwr_bridge_pkg;
    localparam int AV_ADDR_NBIT = 24;
    localparam int AV_DATA_NBIT = 32;
    localparam int AV_BE_NBIT = 4;
    localparam int OUT_NBIT = 4;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ISSUE} state_t;

    // Byte lanes above the inbound data width are tied inactive (1 on an active-low bus)
    function automatic logic [AV_BE_NBIT-1:0] pad_lanes(input int nbytes);
        return 4'(4'hF << nbytes);
    endfunction
endpackage

// File: rtl/avalon_memwr_bridge_if.sv
// avalon_memwr_bridge_if: inbound request port and Avalon-MM master port bundled together
interface avalon_memwr_bridge_if
    import avalon_memwr_bridge_pkg::*;
#(
    parameter int P_DATA_NBIT = 32,
    parameter int P_ADDR_NBIT = 24
);
    logic [P_ADDR_NBIT-1:0]   inb_address;
    logic                     inb_write;
    logic [P_DATA_NBIT-1:0]   inb_wdata;
    logic [P_DATA_NBIT/8-1:0] inb_byteen;
    logic                     inb_read;
    logic                     inb_ready;
    logic [P_DATA_NBIT-1:0]   inb_rdata;
    logic                     inb_datavalid;
    logic                     inb_initdone;
    logic                     inb_cmd_err;
    logic [AV_ADDR_NBIT-1:0]  avalon_address;
    logic [AV_BE_NBIT-1:0]    avalon_byteenable_n;
    logic                     avalon_chipselect;
    logic [AV_DATA_NBIT-1:0]  avalon_writedata;
    logic                     avalon_read_n;
    logic                     avalon_write_n;
    logic [AV_DATA_NBIT-1:0]  avalon_readdata;
    logic                     avalon_readdatavalid;
    logic                     avalon_waitrequest;

    modport master (
        input  inb_address, inb_write, inb_wdata, inb_byteen, inb_read,
        input  avalon_readdata, avalon_readdatavalid, avalon_waitrequest,
        output inb_ready, inb_rdata, inb_datavalid, inb_initdone, inb_cmd_err,
        output avalon_address, avalon_byteenable_n, avalon_chipselect,
        output avalon_writedata, avalon_read_n, avalon_write_n
    );

    modport slave (
        output inb_address, inb_write, inb_wdata, inb_byteen, inb_read,
        output avalon_readdata, avalon_readdatavalid, avalon_waitrequest,
        input  inb_ready, inb_rdata, inb_datavalid, inb_initdone, inb_cmd_err,
        input  avalon_address, avalon_byteenable_n, avalon_chipselect,
        input  avalon_writedata, avalon_read_n, avalon_write_n
    );
endinterface

// File: rtl/avalon_memwr_bridge_cmd_fifo.sv
// avalon_memwr_bridge_cmd_fifo: synchronous command FIFO; head shows the oldest entry
module avalon_memwr_bridge_cmd_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;

    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign head = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
endmodule

// File: rtl/avalon_memwr_bridge.sv
// avalon_memwr_bridge: queued, waitrequest-aware bridge from inbound requests to an Avalon-MM master
module avalon_memwr_bridge
    import avalon_memwr_bridge_pkg::*;
#(
    parameter int P_DATA_NBIT = 32,
    parameter int P_ADDR_NBIT = 24,
    parameter int P_FIFO_DEPTH = 4,
    parameter int P_MAX_RD = 4
) (
    input logic clk,
    input logic rst,
    avalon_memwr_bridge_if.master bus
);
    localparam int BN = P_DATA_NBIT / 8;
    localparam int W = 1 + P_ADDR_NBIT + BN + P_DATA_NBIT;
    localparam logic [AV_BE_NBIT-1:0] PAD = pad_lanes(BN);

    state_t                 state, state_n;
    logic                   full, empty, push, pop, accept, acc_rd, dec, elig, initdone;
    logic [W-1:0]           head;
    logic                   h_wr;
    logic [P_ADDR_NBIT-1:0] h_addr;
    logic [BN-1:0]          h_be;
    logic [P_DATA_NBIT-1:0] h_data;
    logic [OUT_NBIT-1:0]    outst;

    assign {h_wr, h_addr, h_be, h_data} = head;
    assign bus.inb_ready = initdone & ~full;
    assign bus.inb_initdone = initdone;
    assign push = bus.inb_ready & (bus.inb_write | bus.inb_read);
    assign accept = state == ST_ISSUE && !bus.avalon_waitrequest;
    assign acc_rd = accept & ~bus.avalon_read_n;
    assign dec = bus.avalon_readdatavalid & (outst != '0);
    // A read being accepted this cycle already occupies a slot for the next head
    assign elig = ~empty & (h_wr | ({1'b0, outst} + (OUT_NBIT+1)'(acc_rd) < (OUT_NBIT+1)'(P_MAX_RD)));

    avalon_memwr_bridge_cmd_fifo #(.W(W), .DEPTH(P_FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din({bus.inb_write, bus.inb_address, bus.inb_byteen, bus.inb_wdata}),
        .full(full),
        .empty(empty),
        .head(head)
    );

    always_ff @(posedge clk)
        state <= rst ? ST_INIT : state_n;

    always_comb begin
        state_n = state;
        pop = 1'b0;
        case (state)
            ST_INIT: state_n = bus.avalon_waitrequest ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                pop = elig;
                state_n = elig ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                pop = accept & elig;
                state_n = accept & ~elig ? ST_IDLE : ST_ISSUE;
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.avalon_chipselect <= 1'b0;
            bus.avalon_read_n <= 1'b1;
            bus.avalon_write_n <= 1'b1;
            bus.avalon_byteenable_n <= 4'hF;
            bus.avalon_address <= '0;
            bus.avalon_writedata <= '0;
        end else if (pop) begin
            bus.avalon_chipselect <= 1'b1;
            bus.avalon_read_n <= h_wr;
            bus.avalon_write_n <= ~h_wr;
            bus.avalon_byteenable_n <= PAD | (h_wr ? ~4'(h_be) : 4'h0);
            bus.avalon_address <= AV_ADDR_NBIT'(h_addr);
            bus.avalon_writedata <= AV_DATA_NBIT'(h_data);
        end else if (accept) begin
            bus.avalon_chipselect <= 1'b0;
            bus.avalon_read_n <= 1'b1;
            bus.avalon_write_n <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            initdone <= 1'b0;
            outst <= '0;
            bus.inb_cmd_err <= 1'b0;
            bus.inb_datavalid <= 1'b0;
            bus.inb_rdata <= '0;
        end else begin
            initdone <= initdone | (state == ST_INIT && !bus.avalon_waitrequest);
            outst <= outst + OUT_NBIT'(acc_rd) - OUT_NBIT'(dec);
            bus.inb_cmd_err <= push & bus.inb_write & bus.inb_read;
            bus.inb_datavalid <= dec;
            if (dec) bus.inb_rdata <= bus.avalon_readdata[P_DATA_NBIT-1:0];
        end
    end
endmodule

// File: tb/tb_avalon_memwr_bridge.sv
// tb_avalon_memwr_bridge: directed checks of init, stalls, read pipelining, FIFO full, error strobe, reset
module tb_avalon_memwr_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_rd_acc = 0;
    int out_cnt = 0;
    int max_out = 0;
    int rd0, g0;
    logic [31:0] rq_data[$];
    int          rq_due[$];
    logic [31:0] got[$];
    logic [23:0] wr_addr[$];
    logic [31:0] wr_data[$];

    avalon_memwr_bridge_if #(.P_DATA_NBIT(32), .P_ADDR_NBIT(24)) bus ();

    avalon_memwr_bridge #(
        .P_DATA_NBIT(32), .P_ADDR_NBIT(24), .P_FIFO_DEPTH(4), .P_MAX_RD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Avalon slave model: fixed 8-cycle read latency, data derived from address
    always @(posedge clk) begin
        cyc++;
        if (bus.avalon_chipselect && !bus.avalon_read_n && !bus.avalon_waitrequest) begin
            rq_data.push_back(32'hD000_0000 | 32'(bus.avalon_address));
            rq_due.push_back(cyc + 8);
            n_rd_acc++;
            out_cnt++;
            if (out_cnt > max_out) max_out = out_cnt;
        end
        if (bus.avalon_chipselect && !bus.avalon_write_n && !bus.avalon_waitrequest) begin
            wr_addr.push_back(bus.avalon_address);
            wr_data.push_back(bus.avalon_writedata);
        end
        if (bus.inb_datavalid) got.push_back(bus.inb_rdata);
        #1;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            bus.avalon_readdata = rq_data.pop_front();
            void'(rq_due.pop_front());
            bus.avalon_readdatavalid = 1'b1;
            out_cnt--;
        end else begin
            bus.avalon_readdatavalid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic w, input logic r, input logic [23:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        bus.inb_write = w;
        bus.inb_read = r;
        bus.inb_address = a;
        bus.inb_wdata = d;
        bus.inb_byteen = be;
        for (int n = 0; n < 200 && !bus.inb_ready; n++) tick();
        chk("push_ready", bus.inb_ready, 1'b1);
        tick();
        bus.inb_write = 1'b0;
        bus.inb_read = 1'b0;
    endtask

    initial begin
        bus.avalon_waitrequest = 1'b1;
        bus.inb_write = 1'b0;
        bus.inb_read = 1'b0;
        bus.inb_address = '0;
        bus.inb_wdata = '0;
        bus.inb_byteen = '0;
        // T1: reset values, init held off by waitrequest
        repeat (5) tick();
        chk("t1_cs", bus.avalon_chipselect, 1'b0);
        chk("t1_rd_n", bus.avalon_read_n, 1'b1);
        chk("t1_wr_n", bus.avalon_write_n, 1'b1);
        chk("t1_be_n", bus.avalon_byteenable_n, 4'hF);
        chk("t1_addr", bus.avalon_address, 24'h0);
        chk("t1_wdata", bus.avalon_writedata, 32'h0);
        chk("t1_ready", bus.inb_ready, 1'b0);
        chk("t1_dv", bus.inb_datavalid, 1'b0);
        chk("t1_rdata", bus.inb_rdata, 32'h0);
        chk("t1_initdone", bus.inb_initdone, 1'b0);
        chk("t1_cmd_err", bus.inb_cmd_err, 1'b0);
        rst = 1'b0;
        repeat (20) tick();
        chk("t1_init_wait", bus.inb_initdone, 1'b0);
        chk("t1_ready_wait", bus.inb_ready, 1'b0);
        chk("t1_cs_wait", bus.avalon_chipselect, 1'b0);
        chk("t1_be_wait", bus.avalon_byteenable_n, 4'hF);
        bus.avalon_waitrequest = 1'b0;
        chk("t1_init_reg", bus.inb_initdone, 1'b0);
        tick();
        chk("t1_init_set", bus.inb_initdone, 1'b1);
        chk("t1_ready_set", bus.inb_ready, 1'b1);
        chk("t1_cs_idle", bus.avalon_chipselect, 1'b0);

        // T2: one write held through three stall cycles
        push_req(1'b1, 1'b0, 24'h000010, 32'hA5A5_0001, 4'b0011);
        bus.avalon_waitrequest = 1'b1;
        tick();
        chk("t2_cs", bus.avalon_chipselect, 1'b1);
        chk("t2_wr_n", bus.avalon_write_n, 1'b0);
        chk("t2_rd_n", bus.avalon_read_n, 1'b1);
        chk("t2_be_n", bus.avalon_byteenable_n, 4'b1100);
        chk("t2_addr", bus.avalon_address, 24'h000010);
        chk("t2_wdata", bus.avalon_writedata, 32'hA5A5_0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_cs", bus.avalon_chipselect, 1'b1);
            chk("t2_hold_addr", bus.avalon_address, 24'h000010);
            chk("t2_hold_wr_n", bus.avalon_write_n, 1'b0);
        end
        bus.avalon_waitrequest = 1'b0;
        tick();
        chk("t2_idle_cs", bus.avalon_chipselect, 1'b0);
        chk("t2_idle_wr_n", bus.avalon_write_n, 1'b1);
        chk("t2_nwr", wr_addr.size(), 1);
        chk("t2_wr_data", wr_data[0], 32'hA5A5_0001);

        // T3: six reads, at most four outstanding
        for (int i = 0; i < 6; i++) push_req(1'b0, 1'b1, 24'(i), 32'h0, 4'h0);
        repeat (3) tick();
        chk("t3_issued", n_rd_acc, 4);
        chk("t3_cs_wait", bus.avalon_chipselect, 1'b0);
        chk("t3_no_dv_yet", got.size(), 0);
        for (int n = 0; n < 50 && !bus.avalon_readdatavalid; n++) tick();
        chk("t3_rdv_seen", bus.avalon_readdatavalid, 1'b1);
        chk("t3_dv_lat0", bus.inb_datavalid, 1'b0);
        tick();
        chk("t3_dv_lat1", bus.inb_datavalid, 1'b1);
        chk("t3_rdata0", bus.inb_rdata, 32'hD000_0000);
        for (int n = 0; n < 100 && got.size() < 6; n++) tick();
        repeat (3) tick();
        chk("t3_ndv", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk("t3_order", got[i], 32'hD000_0000 | 32'(i));
        chk("t3_max_out", max_out, 4);
        chk("t3_total_rd", n_rd_acc, 6);

        // T4: stalled bus fills the FIFO; extra write waits for the drain
        wr_addr.delete();
        wr_data.delete();
        bus.avalon_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) push_req(1'b1, 1'b0, 24'h20 + 24'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
        chk("t4_full", bus.inb_ready, 1'b0);
        bus.inb_write = 1'b1;
        bus.inb_address = 24'h25;
        bus.inb_wdata = 32'hC0DE_0005;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_ready_low", bus.inb_ready, 1'b0);
        end
        chk("t4_none_yet", wr_addr.size(), 0);
        bus.avalon_waitrequest = 1'b0;
        push_req(1'b1, 1'b0, 24'h25, 32'hC0DE_0005, 4'hF);
        for (int n = 0; n < 100 && wr_addr.size() < 6; n++) tick();
        repeat (3) tick();
        chk("t4_nwr", wr_addr.size(), 6);
        for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
            chk("t4_addr", wr_addr[i], 24'h20 + 24'(i));
            chk("t4_data", wr_data[i], 32'hC0DE_0000 + 32'(i));
        end

        // T5: simultaneous write and read
        wr_addr.delete();
        wr_data.delete();
        rd0 = n_rd_acc;
        chk("t5_err_before", bus.inb_cmd_err, 1'b0);
        bus.inb_write = 1'b1;
        bus.inb_read = 1'b1;
        bus.inb_address = 24'h30;
        bus.inb_wdata = 32'h1234_5678;
        bus.inb_byteen = 4'hF;
        chk("t5_ready", bus.inb_ready, 1'b1);
        tick();
        bus.inb_write = 1'b0;
        bus.inb_read = 1'b0;
        chk("t5_err_pulse", bus.inb_cmd_err, 1'b1);
        tick();
        chk("t5_err_clear", bus.inb_cmd_err, 1'b0);
        repeat (4) tick();
        chk("t5_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) chk("t5_addr", wr_addr[0], 24'h30);
        chk("t5_no_read", n_rd_acc, rd0);

        // T6: reset with two reads in flight and three queued
        rd0 = n_rd_acc;
        g0 = got.size();
        push_req(1'b0, 1'b1, 24'h40, 32'h0, 4'h0);
        push_req(1'b0, 1'b1, 24'h41, 32'h0, 4'h0);
        tick();
        tick();
        bus.avalon_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) push_req(1'b0, 1'b1, 24'h42 + 24'(i), 32'h0, 4'h0);
        chk("t6_inflight", n_rd_acc, rd0 + 2);
        chk("t6_cs_stalled", bus.avalon_chipselect, 1'b1);
        rst = 1'b1;
        tick();
        chk("t6_cs", bus.avalon_chipselect, 1'b0);
        chk("t6_rd_n", bus.avalon_read_n, 1'b1);
        chk("t6_be_n", bus.avalon_byteenable_n, 4'hF);
        chk("t6_addr", bus.avalon_address, 24'h0);
        chk("t6_ready", bus.inb_ready, 1'b0);
        chk("t6_initdone", bus.inb_initdone, 1'b0);
        rst = 1'b0;
        repeat (15) tick();
        chk("t6_late_dv", got.size(), g0);
        chk("t6_dv_low", bus.inb_datavalid, 1'b0);
        chk("t6_rdata", bus.inb_rdata, 32'h0);
        bus.avalon_waitrequest = 1'b0;
        repeat (2) tick();
        chk("t6_reinit", bus.inb_initdone, 1'b1);
        repeat (5) tick();
        chk("t6_dropped", n_rd_acc, rd0 + 2);
        chk("t6_idle", bus.avalon_chipselect, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
